// File: rtl/poly_mode_pkg.sv
// Shared types and constants for the polymorphic-gate supply-mode sequencer.
package poly_mode_pkg;

  // Sequencer states, in the order a mode switch walks through them.
  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SLEEP,
    ISO,
    SWITCH,
    SETTLE,
    WAKE
  } state_e;

  // vdd_sel encodings: high supply selects the OR-type function, low the AND-type.
  localparam logic VDD_HIGH = 1'b1;
  localparam logic VDD_LOW  = 1'b0;

endpackage : poly_mode_pkg

// File: rtl/poly_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-high reset to 0.
module poly_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through STAGES flops; the last one is safe to use.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops that hold state are always written with <=; blocking writes here
    // would collapse the chain into a single flop in simulation.
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : poly_sync

// File: rtl/poly_mode_ctrl.sv
// Supply-mode sequencer for a bank of polymorphic NCL threshold gates.
// Drains the pipeline, sleeps and isolates the gates, flips vdd_sel, waits for the
// rail to settle, then reopens and wakes the datapath.
// Optional feature: define POLY_MODE_TIMEOUT_EN to add a drain watchdog that sets a
// sticky err flag and aborts back to IDLE; without it DRAIN waits indefinitely and
// err is tied to 0.
module poly_mode_ctrl
  import poly_mode_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int ISO_CYCLES     = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_mode,
  output logic req_ready,
  input  logic ko_null,
  output logic vdd_sel,
  output logic sleep_all,
  output logic tg_ctrl,
  output logic busy,
  output logic done,
  output logic err
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("poly_mode_ctrl: SYNC_STAGES must be at least 2");
  end
  if (ISO_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_zero
    $error("poly_mode_ctrl: cycle-count parameters must be non-zero");
  end
  if ((ISO_CYCLES - 1) >= (1 << CNT_W) || (SETTLE_CYCLES - 1) >= (1 << CNT_W) ||
      (TIMEOUT_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_width
    $error("poly_mode_ctrl: CNT_W too narrow for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] ISO_LOAD    = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             ko_sync;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tgt_q;
  logic             vdd_sel_q;
  logic             sleep_q;
  logic             tg_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;
  logic             err_q;

  poly_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ko_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ko_null),
    .q_o (ko_sync)
  );

  // Sequencer: state, cycle counter and every output are registered here, and each
  // output takes the value of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Reset parks in WAKE with the gates asleep and isolated; the first clock then
      // opens them and lands in IDLE.
      state_q   <= WAKE;
      cnt_q     <= '0;
      tgt_q     <= VDD_HIGH;
      vdd_sel_q <= VDD_HIGH;
      sleep_q   <= 1'b1;
      tg_q      <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            if (req_mode == vdd_sel_q) begin
              // Already in the requested mode: acknowledge without touching the rail.
              done_q <= 1'b1;
            end else begin
              tgt_q   <= req_mode;
              state_q <= DRAIN;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
`ifdef POLY_MODE_TIMEOUT_EN
              cnt_q   <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            end
          end
        end

        DRAIN: begin
          if (ko_sync) begin
            state_q <= SLEEP;
            sleep_q <= 1'b1;
          end
`ifdef POLY_MODE_TIMEOUT_EN
          else if (cnt_q == '0) begin
            // Pipeline never drained: give up with the rail and gates untouched.
            err_q   <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
`endif
        end

        SLEEP: begin
          // Require NULL to still hold with sleep applied before isolating.
          if (ko_sync) begin
            state_q <= ISO;
            tg_q    <= 1'b0;
            cnt_q   <= ISO_LOAD;
          end
        end

        ISO: begin
          if (cnt_q == '0) begin
            // The rail flips as SWITCH is entered, and the settle window starts with
            // it, so the settle count is loaded on the same edge.
            state_q   <= SWITCH;
            vdd_sel_q <= tgt_q;
            cnt_q     <= SETTLE_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        SWITCH: begin
          state_q <= SETTLE;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= WAKE;
            tg_q    <= 1'b1;
            sleep_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        WAKE: begin
          // A WAKE reached from reset still has the gates isolated; only a WAKE that
          // ends a real switch sequence reports completion.
          state_q <= IDLE;
          tg_q    <= 1'b1;
          sleep_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= tg_q;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign vdd_sel   = vdd_sel_q;
  assign sleep_all = sleep_q;
  assign tg_ctrl   = tg_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef POLY_MODE_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule : poly_mode_ctrl

// File: tb/tb_poly_mode_ctrl.sv
// Self-checking bench for poly_mode_ctrl: table of mode requests plus hand-written
// reset-mid-sequence and (with POLY_MODE_TIMEOUT_EN) drain-timeout sequences.
module tb_poly_mode_ctrl;

  localparam int SYNC_STAGES    = 2;
  localparam int ISO_CYCLES     = 4;
  localparam int SETTLE_CYCLES  = 16;
  localparam int CNT_W          = 8;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int BUDGET         = 400;

  logic clk = 1'b0;
  logic rst, req_valid, req_mode, ko_null;
  logic req_ready, vdd_sel, sleep_all, tg_ctrl, busy, done, err;

  int checks = 0;
  int errors = 0;
  logic prev_vdd;

  typedef struct {
    logic mode;
    int   ko_delay;
    logic exp_seq;
    logic exp_vdd;
  } vec_t;

  vec_t tbl[6];

  poly_mode_ctrl #(
    .SYNC_STAGES   (SYNC_STAGES),
    .ISO_CYCLES    (ISO_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_mode (req_mode),
    .req_ready(req_ready),
    .ko_null  (ko_null),
    .vdd_sel  (vdd_sel),
    .sleep_all(sleep_all),
    .tg_ctrl  (tg_ctrl),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_vdd, input logic exp_err);
    check({tag, "_vdd"}, vdd_sel, exp_vdd);
    check({tag, "_tg"}, tg_ctrl, 1'b1);
    check({tag, "_sleep"}, sleep_all, 1'b0);
    check({tag, "_ready"}, req_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, exp_err);
  endtask

  // One table entry: issue the request, then time every edge of the sequence.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    int t_sleep, t_tgf, t_vdd, t_tgr, t_done, exp_sleep;
    bit drain_ok, guard_ok;
    tag = $sformatf("v%0d", idx);
    if (v.ko_delay > 0) begin
      ko_null = 1'b0;
      repeat (SYNC_STAGES + 1) tick();
    end
    check({tag, "_ready_pre"}, req_ready, 1'b1);
    req_mode  = v.mode;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    if (!v.exp_seq) begin
      check({tag, "_done_now"}, done, 1'b1);
      check({tag, "_busy_now"}, busy, 1'b0);
      check({tag, "_tg_now"}, tg_ctrl, 1'b1);
      check({tag, "_sleep_now"}, sleep_all, 1'b0);
      check({tag, "_vdd_now"}, vdd_sel, v.exp_vdd);
      tick();
      check({tag, "_done_once"}, done, 1'b0);
    end else begin
      check({tag, "_busy_acc"}, busy, 1'b1);
      check({tag, "_ready_acc"}, req_ready, 1'b0);
      t_sleep = -1; t_tgf = -1; t_vdd = -1; t_tgr = -1; t_done = -1;
      drain_ok = 1'b1;
      guard_ok = 1'b1;
      for (int n = 1; n <= BUDGET && t_done < 0; n++) begin
        if (v.ko_delay > 0 && n - 1 == v.ko_delay) ko_null = 1'b1;
        // A competing request while busy must not alter the captured target.
        if (n >= 2 && n <= 5) begin
          req_valid = 1'b1;
          req_mode  = ~v.mode;
        end else begin
          req_valid = 1'b0;
        end
        tick();
        if (t_sleep < 0 && sleep_all === 1'b1) t_sleep = n;
        if (t_tgf < 0 && tg_ctrl === 1'b0) t_tgf = n;
        if (t_vdd < 0 && vdd_sel === v.exp_vdd) begin
          t_vdd = n;
          if (tg_ctrl !== 1'b0 || sleep_all !== 1'b1) guard_ok = 1'b0;
        end
        if (t_tgf >= 0 && t_tgr < 0 && tg_ctrl === 1'b1) t_tgr = n;
        if (done === 1'b1) t_done = n;
        if (t_sleep < 0 && (tg_ctrl !== 1'b1 || vdd_sel !== prev_vdd)) drain_ok = 1'b0;
      end
      req_valid = 1'b0;
      exp_sleep = (v.ko_delay == 0) ? 1 : v.ko_delay + SYNC_STAGES + 1;
      check({tag, "_sleep_at"}, t_sleep, exp_sleep);
      check({tag, "_drain_quiet"}, drain_ok, 1'b1);
      check({tag, "_tg_fall_gap"}, t_tgf - t_sleep, 1);
      check({tag, "_iso_gap"}, t_vdd - t_tgf, ISO_CYCLES);
      check({tag, "_vdd_guard"}, guard_ok, 1'b1);
      check({tag, "_settle_gap"}, t_tgr - t_vdd, SETTLE_CYCLES);
      check({tag, "_done_gap"}, t_done - t_tgr, 1);
      check_idle({tag, "_end"}, v.exp_vdd, 1'b0);
      tick();
      check({tag, "_done_once"}, done, 1'b0);
    end
    ko_null  = 1'b1;
    prev_vdd = v.exp_vdd;
    repeat (3) tick();
  endtask

  initial begin
    int t_abort;
    bit seen_done, err_early;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mode  = 1'b1;
    ko_null   = 1'b1;
    prev_vdd  = 1'b1;

    tbl[0] = '{mode: 1'b0, ko_delay: 0,  exp_seq: 1'b1, exp_vdd: 1'b0};
    tbl[1] = '{mode: 1'b0, ko_delay: 0,  exp_seq: 1'b0, exp_vdd: 1'b0};
    tbl[2] = '{mode: 1'b1, ko_delay: 0,  exp_seq: 1'b1, exp_vdd: 1'b1};
    tbl[3] = '{mode: 1'b1, ko_delay: 0,  exp_seq: 1'b0, exp_vdd: 1'b1};
    tbl[4] = '{mode: 1'b0, ko_delay: 50, exp_seq: 1'b1, exp_vdd: 1'b0};
    tbl[5] = '{mode: 1'b1, ko_delay: 5,  exp_seq: 1'b1, exp_vdd: 1'b1};

    // Reset values while reset is held.
    repeat (3) tick();
    check("rst_vdd", vdd_sel, 1'b1);
    check("rst_sleep", sleep_all, 1'b1);
    check("rst_tg", tg_ctrl, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", req_ready, 1'b0);
    rst = 1'b0;
    tick();
    check_idle("post_rst", 1'b1, 1'b0);
    check("post_rst_done", done, 1'b0);
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

`ifdef POLY_MODE_TIMEOUT_EN
    // Drain never completes: watchdog aborts to IDLE with err set and no done.
    ko_null = 1'b0;
    repeat (SYNC_STAGES + 1) tick();
    req_mode  = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    t_abort   = -1;
    seen_done = 1'b0;
    err_early = 1'b0;
    for (int n = 1; n <= BUDGET && t_abort < 0; n++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
      if (busy === 1'b0) t_abort = n;
      else if (err !== 1'b0) err_early = 1'b1;
    end
    check("to_abort_at", t_abort, TIMEOUT_CYCLES);
    check("to_err_early", err_early, 1'b0);
    check("to_no_done", seen_done, 1'b0);
    check_idle("to_end", 1'b1, 1'b1);
    ko_null = 1'b1;
    repeat (5) tick();
    check("to_err_sticky", err, 1'b1);
    check("to_no_done_later", done, 1'b0);
`endif

    // Reset during SETTLE: outputs return to reset values without waiting for a clock.
    req_mode  = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    t_abort   = -1;
    for (int n = 1; n <= BUDGET && t_abort < 0; n++) begin
      tick();
      if (vdd_sel === 1'b0) t_abort = n;
    end
    check("mid_vdd_flipped", vdd_sel, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_vdd", vdd_sel, 1'b1);
    check("mid_rst_sleep", sleep_all, 1'b1);
    check("mid_rst_tg", tg_ctrl, 1'b0);
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_ready", req_ready, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_idle("mid_post", 1'b1, 1'b0);
    check("mid_post_done", done, 1'b0);
    repeat (SETTLE_CYCLES) tick();
    check("mid_tgt_dropped", vdd_sel, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_poly_mode_ctrl

// File: doc/poly_mode_ctrl.md
Name: poly_mode_ctrl

Overview:
- Clocked sequencer that safely switches the shared vdd_sel line of a bank of polymorphic NCL threshold gates between high-supply and low-supply functions.
- Waits for the asynchronous pipeline to drain to NULL, asserts sleep on all stages, and isolates outputs through the transmission gates.
- Flips vdd_sel, lets the rail settle, then reopens and wakes the datapath.
- Sits between the system mode/configuration logic and the polymorphic gate array.

Parameters:
- SYNC_STAGES, 2, flops in the synchronizer for the async ko_null completion input (min 2).
- ISO_CYCLES, 4, cycles tg_ctrl is held low before vdd_sel changes.
- SETTLE_CYCLES, 16, cycles after a vdd_sel change before isolation is released.
- CNT_W, 8, cycle-counter width; must hold max(ISO_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES).
- TIMEOUT_CYCLES, 200, drain watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  mode-change request
- req_mode  in  1  target vdd_sel value (1 = high/OR-type function, 0 = low/AND-type function)
- req_ready  out  1  controller can accept a request
- ko_null  in  1  async completion: 1 when every stage holds NULL
- vdd_sel  out  1  polymorphic gate function select
- sleep_all  out  1  forces all gate s/s0 inputs to 1 (output 0)
- tg_ctrl  out  1  transmission gate enable (1 = pass)
- busy  out  1  switch sequence in progress
- done  out  1  one-cycle pulse when a sequence completes
- err  out  1  sticky drain-timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values: vdd_sel=1, sleep_all=1, tg_ctrl=0, busy=1, done=0, err=0, req_ready=0. State=WAKE with counter=0; the first post-reset cycle enters IDLE with sleep_all=0 and tg_ctrl=1.
- ko_null passes through SYNC_STAGES flops; all decisions use ko_sync. Synchronizer flops reset to 0.
- Handshake: a request is accepted on a cycle where req_valid && req_ready. The request is captured into tgt.
  - req_ready=1 only in IDLE.
  - If req_mode == vdd_sel on acceptance: no sequence runs; done pulses on the next cycle and the controller stays IDLE.
- IDLE: busy=0, tg_ctrl=1, sleep_all=0. A differing-mode acceptance moves to DRAIN and sets busy=1 on the next cycle.
- DRAIN: waits for ko_sync==1, then moves to SLEEP.
- SLEEP: sleep_all=1. After one cycle with ko_sync==1, moves to ISO and loads the counter with ISO_CYCLES-1. If ko_sync==0, stays in SLEEP.
- ISO: tg_ctrl=0, sleep_all=1. Counts down to 0, then moves to SWITCH.
- SWITCH (1 cycle): vdd_sel<=tgt, counter loads SETTLE_CYCLES-1, then moves to SETTLE.
- SETTLE: counts down to 0, then moves to WAKE.
- WAKE (1 cycle): tg_ctrl=1, sleep_all=0. Next state IDLE with done=1 in that IDLE cycle and busy=0.
- vdd_sel changes only in SWITCH. It never changes while tg_ctrl=1 or sleep_all=0.
- req_valid is ignored while busy. Requests are not queued; the requester holds req_valid until req_ready.
- Counters saturate at 0 and do not wrap. Parameter values of 0 are illegal and are flagged by an elaboration-time check.
- Reset mid-sequence: all outputs return immediately (asynchronously) to their reset values. Any pending tgt is discarded.

Optional Feature:
- Macro: POLY_MODE_TIMEOUT_EN.
- Defined:
  - The counter runs in DRAIN. If ko_sync stays 0 for TIMEOUT_CYCLES, the controller sets err=1 (sticky until rst) and aborts to IDLE.
  - The abort leaves vdd_sel unchanged, keeps sleep_all=0 and tg_ctrl=1, and does not pulse done.
- Undefined: DRAIN waits indefinitely. The err port exists and is tied 0.

Decomposition:
- Package poly_mode_pkg holds:
  - The state enum: IDLE, DRAIN, SLEEP, ISO, SWITCH, SETTLE, WAKE.
  - Constants VDD_HIGH=1 and VDD_LOW=0.
- One sub-module: poly_sync, a SYNC_STAGES-deep single-bit synchronizer with asynchronous active-high reset to 0, instantiated for ko_null.

Test Plan:
- Reset, then idle with ko_null=1 → vdd_sel=1, tg_ctrl=1, sleep_all=0, req_ready=1 at cycle 2.
- req_mode=0, ko_null=1, defaults → busy rises; tg_ctrl falls; vdd_sel goes 0 exactly ISO_CYCLES cycles after tg_ctrl falls; tg_ctrl returns 1 SETTLE_CYCLES cycles later; done pulses once.
- req_mode=0 with ko_null held 0 for 50 cycles, then 1 → controller stays in DRAIN with sleep_all=0 and vdd_sel=1 throughout; the sequence completes normally after ko_null rises + SYNC_STAGES.
- req_mode equal to the current vdd_sel → no tg_ctrl/sleep_all activity; done pulses on the next cycle.
- rst asserted during SETTLE → same-cycle outputs vdd_sel=1, sleep_all=1, tg_ctrl=0; after release, normal IDLE with vdd_sel=1.
- With POLY_MODE_TIMEOUT_EN, ko_null=0 for 200 cycles → err=1, return to IDLE, vdd_sel unchanged, no done pulse.
